// File: rtl/cas_pkg.sv
// ============================================================================
// Module   : cas_pkg
// Purpose  : Shared constants, FSM encoding and counter sizing for the sorter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cas_pkg;

    localparam int SNG_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // A two-entry batch still needs a one-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cas.sv
// ============================================================================
// Module   : cas
// Purpose  : Combinational compare-and-swap; the larger operand leaves on a_new.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cas
    import cas_pkg::*;
#(
    parameter int WIDTH = SNG_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] a_new,
    output logic [WIDTH-1:0] b_new
);

    logic borrow;

    // Borrow out of the widened a-b is set exactly when a < b; ties keep order.
    assign borrow = 1'(({1'b0, a} - {1'b0, b}) >> WIDTH);

    assign a_new = borrow ? b : a;
    assign b_new = borrow ? a : b;

endmodule

`default_nettype wire

// File: rtl/cas_oets_sorter.sv
// ============================================================================
// Module   : cas_oets_sorter
// Purpose  : Load a batch, sort it by odd-even transposition, drain largest first.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cas_oets_sorter
    import cas_pkg::*;
#(
    parameter int SNG_WIDTH  = SNG_WIDTH_DEFAULT,
    parameter int NUM_INPUTS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SNG_WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SNG_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 busy
);

    localparam int            CW       = cnt_width(NUM_INPUTS);
    localparam int            NP       = NUM_INPUTS / 2;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_INPUTS - 1);

    state_t               state_q, state_d;
    logic [SNG_WIDTH-1:0] mem_q [NUM_INPUTS];
    logic [SNG_WIDTH-1:0] mem_d [NUM_INPUTS];
    logic [CW-1:0]        wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]        rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]        phase_q, phase_d;

    logic [SNG_WIDTH-1:0] cas_a     [NP];
    logic [SNG_WIDTH-1:0] cas_b     [NP];
    logic [SNG_WIDTH-1:0] cas_a_new [NP];
    logic [SNG_WIDTH-1:0] cas_b_new [NP];
    logic                 odd_phase;

    assign odd_phase = phase_q[0];

    // The last cell has no odd-phase partner; its result is ignored then.
    for (genvar k = 0; k < NP; k++) begin : g_cas
        if (k == NP - 1) begin : g_edge
            assign cas_a[k] = mem_q[2*k];
            assign cas_b[k] = mem_q[2*k+1];
        end else begin : g_inner
            assign cas_a[k] = odd_phase ? mem_q[2*k+1] : mem_q[2*k];
            assign cas_b[k] = odd_phase ? mem_q[2*k+2] : mem_q[2*k+1];
        end

        cas #(.WIDTH(SNG_WIDTH)) u_cas (
            .a     (cas_a[k]),
            .b     (cas_b[k]),
            .a_new (cas_a_new[k]),
            .b_new (cas_b_new[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (in_valid && wr_cnt_q == LAST_IDX) state_d = SORT;
            SORT:    if (phase_q == LAST_IDX) state_d = DRAIN;
            DRAIN:   if (out_ready && rd_cnt_q == LAST_IDX) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        out_data  = '0;
        case (state_q)
            LOAD:  in_ready = 1'b1;
            SORT:  busy = 1'b1;
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = mem_q[rd_cnt_q];
                out_last  = (rd_cnt_q == LAST_IDX);
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        phase_d  = phase_q;
        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    for (int i = 0; i < NUM_INPUTS; i++) begin
                        if (CW'(i) == wr_cnt_q) mem_d[i] = in_data;
                    end
                    if (wr_cnt_q == LAST_IDX) begin
                        wr_cnt_d = '0;
                        phase_d  = '0;
                    end else begin
                        wr_cnt_d = wr_cnt_q + CW'(1);
                    end
                end
            end
            SORT: begin
                if (odd_phase) begin
                    for (int k = 0; k < NP - 1; k++) begin
                        mem_d[2*k+1] = cas_a_new[k];
                        mem_d[2*k+2] = cas_b_new[k];
                    end
                end else begin
                    for (int k = 0; k < NP; k++) begin
                        mem_d[2*k]   = cas_a_new[k];
                        mem_d[2*k+1] = cas_b_new[k];
                    end
                end
                if (phase_q == LAST_IDX) begin
                    phase_d  = '0;
                    rd_cnt_d = '0;
                end else begin
                    phase_d = phase_q + CW'(1);
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    rd_cnt_d = (rd_cnt_q == LAST_IDX) ? '0 : rd_cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                mem_q[i] <= '0;
            end
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            phase_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            phase_q  <= phase_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cas_oets_sorter.sv
// ============================================================================
// Module   : tb_cas_oets_sorter
// Purpose  : Self-checking bench for cas_oets_sorter against a batch-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cas_oets_sorter;

    localparam int W = 8;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready, out_valid, out_last, busy;
    logic [W-1:0] out_data;

    always #5 clk = ~clk;

    cas_oets_sorter #(.SNG_WIDTH(W), .NUM_INPUTS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Batch-level model: collect N operands, sort them descending, then wait
    // N cycles and hand them out one per accepted output beat.
    int m_mode;      // 0 collecting, 1 sorting, 2 draining
    int m_cnt;
    int m_idx;
    int m_batch[$];
    int m_sorted[N];
    int m_key, m_j;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0;
            m_cnt  = 0;
            m_idx  = 0;
            m_batch.delete();
        end else begin
            case (m_mode)
                0: if (in_valid) begin
                    m_batch.push_back(int'(in_data));
                    if (m_batch.size() == N) begin
                        for (int i = 0; i < N; i++) m_sorted[i] = m_batch[i];
                        for (int i = 1; i < N; i++) begin
                            m_key = m_sorted[i];
                            m_j   = i - 1;
                            while (m_j >= 0 && m_sorted[m_j] < m_key) begin
                                m_sorted[m_j+1] = m_sorted[m_j];
                                m_j--;
                            end
                            m_sorted[m_j+1] = m_key;
                        end
                        m_batch.delete();
                        m_mode = 1;
                        m_cnt  = 0;
                    end
                end
                1: begin
                    m_cnt++;
                    if (m_cnt == N) begin
                        m_mode = 2;
                        m_idx  = 0;
                    end
                end
                default: if (out_ready) begin
                    m_idx++;
                    if (m_idx == N) m_mode = 0;
                end
            endcase
        end
    end

    logic [W-1:0] got_d[$];
    logic         got_l[$];

    always @(negedge clk) begin
        chk("in_ready",  32'(in_ready),  32'(m_mode == 0));
        chk("busy",      32'(busy),      32'(m_mode != 0));
        chk("out_valid", 32'(out_valid), 32'(m_mode == 2));
        chk("out_last",  32'(out_last),  32'(m_mode == 2 && m_idx == N - 1));
        chk("out_data",  32'(out_data),  (m_mode == 2) ? m_sorted[m_idx] : 0);
        if (out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_l.push_back(out_last);
        end
    end

    int rmode = 0;
    int tog   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom % 2);
            default: begin
                out_ready = (tog % 3 == 0);
                tog++;
            end
        endcase
    endtask

    task automatic load(input logic [W-1:0] v);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = v;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            tick();
        end
        if (!ok) chk("load_timeout", 0, 1);
    endtask

    task automatic wait_out(input int target, input bit junk, output int lat);
        lat = -1;
        for (int t = 1; t <= 300 && got_d.size() < target; t++) begin
            tick();
            if (junk) begin
                in_valid = 1'($urandom % 2);
                in_data  = W'($urandom);
            end
            if (out_valid && lat < 0) lat = t;
        end
        in_valid = 1'b0;
        if (got_d.size() < target) chk("drain_timeout", got_d.size(), target);
    endtask

    task automatic run_batch(input string name, input logic [W-1:0] vin[N],
                             input logic [W-1:0] vexp[N], input bit junk);
        int base, lat;
        base = got_d.size();
        for (int i = 0; i < N; i++) load(vin[i]);
        in_valid = 1'b0;
        wait_out(base + N, junk, lat);
        chk({name, "_latency"}, lat, N);
        for (int i = 0; i < N; i++) begin
            if (base + i < got_d.size()) begin
                chk({name, "_data"}, 32'(got_d[base+i]), 32'(vexp[i]));
                chk({name, "_last"}, 32'(got_l[base+i]), 32'(i == N - 1));
            end
        end
    endtask

    logic [W-1:0] vin[N];
    logic [W-1:0] vexp[N];
    logic [W-1:0] v8[2*N];
    logic [W-1:0] e8[2*N];

    initial begin
        int base, lat;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy",      32'(busy),      0);
        chk("rst_out_data",  32'(out_data),  0);
        chk("rst_out_last",  32'(out_last),  0);
        #1 rst_n = 1'b1;
        tick();

        vin = '{8'd3, 8'd200, 8'd17, 8'd200};  vexp = '{8'd200, 8'd200, 8'd17, 8'd3};
        run_batch("mixed", vin, vexp, 1'b0);
        vin = '{8'd0, 8'd0, 8'd255, 8'd255};   vexp = '{8'd255, 8'd255, 8'd0, 8'd0};
        run_batch("extremes", vin, vexp, 1'b0);
        vin = '{8'd9, 8'd7, 8'd5, 8'd1};       vexp = '{8'd9, 8'd7, 8'd5, 8'd1};
        run_batch("descending", vin, vexp, 1'b0);
        vin = '{8'd1, 8'd5, 8'd7, 8'd9};
        run_batch("ascending", vin, vexp, 1'b0);

        rmode = 2;
        tog   = 0;
        vin = '{8'd11, 8'd44, 8'd22, 8'd33};   vexp = '{8'd44, 8'd33, 8'd22, 8'd11};
        run_batch("stall", vin, vexp, 1'b1);
        rmode = 0;

        // Asynchronous reset in the middle of the sort phases.
        for (int i = 0; i < N; i++) load(W'(10 * (i + 1)));
        in_valid = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midsort_rst_out_valid", 32'(out_valid), 0);
        chk("midsort_rst_in_ready",  32'(in_ready),  1);
        chk("midsort_rst_busy",      32'(busy),      0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick();
        vin = '{8'd4, 8'd3, 8'd2, 8'd1};       vexp = '{8'd4, 8'd3, 8'd2, 8'd1};
        run_batch("after_reset", vin, vexp, 1'b0);

        // Two batches with in_valid held high throughout.
        v8 = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd100, 8'd50, 8'd150, 8'd0};
        e8 = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd150, 8'd100, 8'd50, 8'd0};
        base = got_d.size();
        for (int i = 0; i < 2 * N; i++) begin
            load(v8[i]);
            if (i == N) chk("b2b_second_waits", got_d.size() - base, N);
        end
        in_valid = 1'b0;
        wait_out(base + 2 * N, 1'b0, lat);
        for (int i = 0; i < 2 * N; i++) begin
            if (base + i < got_d.size()) chk("b2b_data", 32'(got_d[base+i]), 32'(e8[i]));
        end

        rmode = 1;
        for (int b = 0; b < 25; b++) begin
            base = got_d.size();
            for (int i = 0; i < N; i++) begin
                in_valid = 1'b0;
                repeat ($urandom % 3) tick();
                load((b % 3 == 0) ? W'($urandom % 4) : W'($urandom));
            end
            in_valid = 1'b0;
            wait_out(base + N, 1'b1, lat);
            chk("random_latency", lat, N);
        end

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
